// File: rtl/fft_tw_pkg.sv
// Shared twiddle definitions for the forward and inverse FFT rotators:
// widths, the quarter-wave cos table, sample types and round/saturate helpers.
package fft_tw_pkg;

  localparam int DW       = 18;
  localparam int FRAC     = 16;
  localparam int TW_STAGE = 7;
  localparam int QW       = 1 << (TW_STAGE - 2);

  typedef logic signed [DW-1:0]   sample_t;
  typedef logic signed [2*DW-1:0] prod_t;
  typedef logic signed [2*DW:0]   acc_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;

  localparam sample_t SMAX = sample_t'({1'b0, {(DW-1){1'b1}}});
  localparam sample_t SMIN = sample_t'({1'b1, {(DW-1){1'b0}}});
  localparam acc_t    RND_HALF = acc_t'(1) << (FRAC - 1);

  // round(cos(2*pi*a/128) * 65536), a = 0..31
  localparam sample_t COS_QW [QW] = '{
    18'sd65536, 18'sd65457, 18'sd65220, 18'sd64827, 18'sd64277, 18'sd63572, 18'sd62714, 18'sd61705,
    18'sd60547, 18'sd59244, 18'sd57798, 18'sd56212, 18'sd54491, 18'sd52639, 18'sd50660, 18'sd48559,
    18'sd46341, 18'sd44011, 18'sd41576, 18'sd39040, 18'sd36410, 18'sd33692, 18'sd30893, 18'sd28020,
    18'sd25080, 18'sd22078, 18'sd19024, 18'sd15924, 18'sd12785, 18'sd9616,  18'sd6424,  18'sd3216
  };

  // sin(theta) = cos(pi/2 - theta); index 32-a wraps to 0 only for a=0, handled explicitly
  function automatic sample_t sin_qw(input logic [TW_STAGE-3:0] a);
    logic [TW_STAGE-3:0] m;
    m = -a;
    return (a == '0) ? '0 : COS_QW[m];
  endfunction

  function automatic acc_t round_frac(input acc_t x);
    return (x + RND_HALF) >>> FRAC;
  endfunction

  function automatic sample_t sat_clip(input acc_t x);
    sample_t r;
    if (x > acc_t'(SMAX))      r = SMAX;
    else if (x < acc_t'(SMIN)) r = SMIN;
    else                       r = x[DW-1:0];
    return r;
  endfunction

  function automatic logic sat_ovf(input acc_t x);
    return (x > acc_t'(SMAX)) || (x < acc_t'(SMIN));
  endfunction

endpackage

// File: rtl/itwiddle_rotator_if.sv
// Complex sample stream with valid/ready handshake and frame-last marker.
interface itwiddle_rotator_if;
  import fft_tw_pkg::*;

  logic    valid;
  logic    ready;
  logic    last;
  sample_t re;
  sample_t im;

  modport master (output valid, re, im, last, input ready);
  modport slave  (input valid, re, im, last, output ready);

endinterface

// File: rtl/itw_rom.sv
// Registered twiddle lookup: quarter-wave table plus quadrant folding for a 7-bit phase.
module itw_rom
  import fft_tw_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [TW_STAGE-1:0] p,
  output sample_t             c,
  output sample_t             s
);

  logic [1:0]          q;
  logic [TW_STAGE-3:0] a;
  sample_t             cq, sq, c_nxt, s_nxt;

  always_comb begin
    q     = p[TW_STAGE-1:TW_STAGE-2];
    a     = p[TW_STAGE-3:0];
    cq    = COS_QW[a];
    sq    = sin_qw(a);
    c_nxt = cq;
    s_nxt = sq;
    case (q)
      2'd1: begin c_nxt = -sq; s_nxt = cq;  end
      2'd2: begin c_nxt = -cq; s_nxt = -sq; end
      2'd3: begin c_nxt = sq;  s_nxt = -cq; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
      s <= '0;
    end else if (en) begin
      c <= c_nxt;
      s <= s_nxt;
    end
  end

endmodule

// File: rtl/itwiddle_rotator.sv
// Inverse-FFT twiddle rotator: y = x * (cos + j sin)(2*pi*p/128), 3-stage pipeline.
// Optional ITW_SAT_FLAG_EN adds a sat_flag output registered with the sample.
module itwiddle_rotator
  import fft_tw_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TW_STAGE-1:0] step,
  itwiddle_rotator_if.slave   sample_in,
  itwiddle_rotator_if.master  sample_out
`ifdef ITW_SAT_FLAG_EN
  ,
  output logic                sat_flag
`endif
);

  logic                en, accept;
  logic [TW_STAGE-1:0] phase;
  logic                v1, v2, v3;
  logic                last1, last2, last3;
  sample_t             re1, im1, c1, s1, re3, im3;
  prod_t               rc2, is2, rs2, ic2;
  acc_t                yr, yi;

  // whole pipeline advances together; a full output register stalls everything
  assign en              = sample_out.ready | ~v3;
  assign accept          = sample_in.valid & en;
  assign sample_in.ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      phase <= '0;
    else if (accept) phase <= sample_in.last ? '0 : phase + step;
  end

  itw_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .p     (phase),
    .c     (c1),
    .s     (s1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      re1   <= '0;
      im1   <= '0;
      last1 <= 1'b0;
      v2    <= 1'b0;
      rc2   <= '0;
      is2   <= '0;
      rs2   <= '0;
      ic2   <= '0;
      last2 <= 1'b0;
    end else if (en) begin
      v1    <= accept;
      re1   <= sample_in.re;
      im1   <= sample_in.im;
      last1 <= sample_in.last;
      v2    <= v1;
      rc2   <= re1 * c1;
      is2   <= im1 * s1;
      rs2   <= re1 * s1;
      ic2   <= im1 * c1;
      last2 <= last1;
    end
  end

  always_comb begin
    yr = round_frac(acc_t'(rc2) - acc_t'(is2));
    yi = round_frac(acc_t'(rs2) + acc_t'(ic2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3    <= 1'b0;
      re3   <= '0;
      im3   <= '0;
      last3 <= 1'b0;
    end else if (en) begin
      v3    <= v2;
      re3   <= sat_clip(yr);
      im3   <= sat_clip(yi);
      last3 <= last2;
    end
  end

`ifdef ITW_SAT_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  sat_flag <= 1'b0;
    else if (en) sat_flag <= sat_ovf(yr) | sat_ovf(yi);
  end
`endif

  assign sample_out.valid = v3;
  assign sample_out.re    = re3;
  assign sample_out.im    = im3;
  assign sample_out.last  = last3;

endmodule

// File: doc/itwiddle_rotator.md
Name: itwiddle_rotator

Overview:
Streaming inverse-FFT twiddle rotator. Each accepted complex sample is multiplied by W^-p = cos(2πp/128) + j·sin(2πp/128). The phase p is an internal 7-bit accumulator.
Sits between IFFT butterfly stages. It is the inverse-direction counterpart of the forward ftwiddle tables, and it also performs the multiply.
Pipelined, 3-cycle latency, valid/ready handshake with full backpressure.

Parameters:
DW, 18, sample width per component, signed two's complement (equals `REAL_WIDTH/`IMGN_WIDTH)
TW_STAGE, 7, twiddle resolution log2 (128 points, 32-entry quarter-wave table)
FRAC, 16, twiddle fraction bits (1.0 = 18'h10000)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
step  in  TW_STAGE  phase increment per accepted sample; sampled at each accept
in_valid  in  1  input sample valid
in_ready  out  1  block can accept
in_re  in  DW  input real
in_im  in  DW  input imaginary
in_last  in  1  last sample of frame
out_valid  out  1  output valid
out_ready  in  1  downstream accepts
out_re  out  DW  rotated real
out_im  out  DW  rotated imaginary
out_last  out  1  in_last delayed with its sample

Behaviour:
- Reset (async assert, sync release): phase=0; all stage valids=0; out_valid=0, out_re=0, out_im=0, out_last=0.
- Pipeline enable: en = out_ready | ~out_valid. in_ready = en (combinational). Accept = in_valid & in_ready.
- When en=0, all stages hold their contents; no bubbles are collapsed.
- Phase: the sample accepted uses the current phase p.
  - After accept: p <= in_last ? 0 : (p + step) mod 128. Wrap is natural 7-bit overflow.
  - p changes only on accept.
- Stage 1: register sample, last flag, and twiddle (c,s) for p.
  - Quadrant q = p[6:5], a = p[4:0].
  - Table gives (C[a], S[a]) = (cos, sin) of 2πa/128, 0 ≤ θ < π/2, round(x·65536), C[0]=18'h10000, S[0]=0.
  - Quadrant mapping: q=0:(C,S); q=1:(−S,C); q=2:(−C,−S); q=3:(S,−C).
- Stage 2: four signed DW×DW products registered: re·c, im·s, re·s, im·c (2·DW bits each).
- Stage 3: yr = re·c − im·s; yi = re·s + im·c (2·DW+1 bits).
  - Round half-up: add 2^(FRAC−1), arithmetic shift right by FRAC.
  - Saturate to [−2^(DW−1), 2^(DW−1)−1]. Register to out_*.
- Latency: 3 cycles from accept to out_valid with no stalls. Throughput: 1 sample/cycle.
- Simultaneous in_last accept and step change: the next sample uses p=0 regardless of step.
- Reset mid-frame: in-flight samples are discarded and p returns to 0.
- Output hold: out_re/out_im/out_last remain stable while out_valid & ~out_ready.

Optional Feature:
ITW_SAT_FLAG_EN
- Defined: adds output port sat_flag (1 bit), registered alongside out_*. It is 1 when either component saturated in stage 3. Reset value 0.
- Undefined: no port. Saturation still occurs, with no indication.

Decomposition:
- Shared package fft_tw_pkg:
  - DW/FRAC/TW_STAGE constants
  - quarter-wave tables
  - complex sample typedef {re,im}
  - saturation helper function
  - also usable by the forward ftwiddle modules
- Sub-module itw_rom: registered quarter-wave lookup plus quadrant mapping. Inputs: p, en. Outputs: c, s.

Test Plan:
- step=0, in=(1000,0) → out=(1000,0) exactly 3 cycles after accept, out_last passes through.
- step=32, samples (1000,0)×4 → outputs (1000,0),(0,1000),(−1000,0),(0,−1000); then p wraps to 0.
- step=16, in=(0x1FFFF,0x1FFFF) on second sample (p=16, 45°) → out_re≈0 (|x|≤1), out_im=0x1FFFF saturated; sat_flag=1 when ITW_SAT_FLAG_EN is defined.
- Backpressure: stream 8 samples, hold out_ready=0 for 5 cycles mid-stream.
  - in_ready=0 while the stall persists and out is stable.
  - No loss or duplication; output order and values match the reference model.
- in_last on sample 3 with step=5 → sample 4 rotates with p=0, samples 1–3 use p=0,5,10.
- Assert rst_n low with 2 samples in flight → out_valid=0 immediately. After release, the first sample uses p=0.
